// File: rtl/decode_stage_pkg.sv
// Shared core package: decoded instruction record, FSM state type and
// RV64 base opcode constants used by decode and the ALU/execute stage.
package decode_stage_pkg;

    localparam int CORE_XLEN = 64;

    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_OP32   = 7'h3B;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_IMM32  = 7'h1B;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_MUL  = 7'h01;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } dec_state_t;

    typedef struct packed {
        logic [6:0]           opcode;
        logic [4:0]           rd;
        logic [2:0]           funct3;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [6:0]           funct7;
        logic [11:0]          imm;
        logic [CORE_XLEN-1:0] imm64;
        logic                 width_32;
        logic                 illegal;
        logic [CORE_XLEN-1:0] pc;
    } decoded_inst_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: extracts the 12-bit ALU immediate (I/S formats only)
// and the fully sign-extended XLEN immediate for every instruction format.
module imm_gen
    import decode_stage_pkg::*;
#(
    parameter int XLEN = CORE_XLEN
) (
    input  logic [31:0]     i_instr,
    output logic [11:0]     o_imm,
    output logic [XLEN-1:0] o_imm64
);

    // Select the immediate layout from the opcode; R-type and unknown give 0
    always_comb begin
        o_imm   = 12'd0;
        o_imm64 = '0;
        case (i_instr[6:0])
            OP_IMM, OP_IMM32, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: begin
                o_imm   = i_instr[31:20];
                o_imm64 = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
            end
            OP_STORE: begin
                o_imm   = {i_instr[31:25], i_instr[11:7]};
                o_imm64 = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            OP_BRANCH: begin
                o_imm64 = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                o_imm64 = {{(XLEN-32){i_instr[31]}}, i_instr[31:12], 12'd0};
            end
            OP_JAL: begin
                o_imm64 = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
            end
            default: begin
                o_imm   = 12'd0;
                o_imm64 = '0;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV64 decode stage: one-entry registered pipeline slot with valid/ready
// handshakes on both sides, flush for branch redirects, and legality checks.
// XLEN must match CORE_XLEN because the decoded record is a package type.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = CORE_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output decoded_inst_t   out_inst,
    input  logic            flush
);

    logic [11:0]     w_imm;
    logic [XLEN-1:0] w_imm64;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic            w_illegal;
    logic            w_accept;
    decoded_inst_t   w_dec;
    dec_state_t      r_state;
    decoded_inst_t   r_inst;

    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];

    imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .i_instr(in_instr),
        .o_imm  (w_imm),
        .o_imm64(w_imm64)
    );

    // Flag unknown opcodes, bad funct7 encodings and out-of-range 32-bit shifts
    always_comb begin
        w_illegal = 1'b0;
        case (in_instr[6:0])
            OP_OP: begin
                if (!(w_funct7 inside {F7_BASE, F7_ALT, F7_MUL})) w_illegal = 1'b1;
            end
            OP_OP32: begin
                if (!(w_funct7 inside {F7_BASE, F7_ALT, F7_MUL})) w_illegal = 1'b1;
                // No MULHW/MULHSUW/MULHUW exist in RV64M
                if (w_funct7 == F7_MUL && w_funct3 inside {3'd1, 3'd2, 3'd3}) w_illegal = 1'b1;
            end
            OP_IMM32: begin
                // SLLIW/SRLIW/SRAIW: shamt bit 5 set is reserved
                if ((w_funct3 == 3'd1 || w_funct3 == 3'd5) && in_instr[25]) w_illegal = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC,
            OP_JAL, OP_JALR, OP_FENCE, OP_SYSTEM: w_illegal = 1'b0;
            default: w_illegal = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11) w_illegal = 1'b1;
    end

    // Assemble the decoded record from raw fields and the immediate generator
    always_comb begin
        w_dec          = '0;
        w_dec.opcode   = in_instr[6:0];
        w_dec.rd       = in_instr[11:7];
        w_dec.funct3   = w_funct3;
        w_dec.rs1      = in_instr[19:15];
        w_dec.rs2      = in_instr[24:20];
        w_dec.funct7   = w_funct7;
        w_dec.imm      = w_imm;
        w_dec.imm64    = w_imm64;
        w_dec.width_32 = (in_instr[6:0] == OP_OP32) || (in_instr[6:0] == OP_IMM32);
        w_dec.illegal  = w_illegal;
        w_dec.pc       = in_pc;
    end

    assign in_ready  = ((r_state == ST_EMPTY) || out_ready) && !flush;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == ST_FULL);
    assign out_inst  = r_inst;

    // Slot FSM: flush wins, then load on accept, else drain when consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_inst  <= '0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else if (w_accept) begin
            r_state <= ST_FULL;
            r_inst  <= w_dec;
        end else if (r_state == ST_FULL && out_ready) begin
            r_state <= ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed RV64 cases plus randomized handshake
// traffic, scoreboarded against an arithmetic reference decoder.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [63:0]   in_pc;
    logic          out_valid;
    logic          out_ready;
    decoded_inst_t out_inst;
    logic          flush;

    int n_cmp = 0;
    int n_err = 0;

    decoded_inst_t sb_q[$];
    logic          pend = 1'b0;
    decoded_inst_t pend_exp;

    logic [6:0] ops_tab[13] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h23, 7'h63,
                                7'h37, 7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73};

    decode_stage #(.XLEN(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .in_pc    (in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst (out_inst),
        .flush    (flush)
    );

    always #5 clk = ~clk;

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_inst(input string nm, input decoded_inst_t act, input decoded_inst_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference decoder: immediates rebuilt as signed integers from bit weights
    function automatic decoded_inst_t ref_decode(input logic [31:0] ins, input logic [63:0] pc);
        decoded_inst_t d;
        int unsigned   u;
        longint        v;
        int            s;
        logic [6:0]    op;
        logic [2:0]    f3;
        logic [6:0]    f7;
        logic          ill;
        d  = '0;
        u  = ins;
        v  = 0;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        d.opcode = op;
        d.rd     = ins[11:7];
        d.funct3 = f3;
        d.rs1    = ins[19:15];
        d.rs2    = ins[24:20];
        d.funct7 = f7;
        case (op)
            7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h0F: begin
                v = longint'(u >> 20);
                if (v >= 2048) v = v - 4096;
                d.imm = v[11:0];
            end
            7'h23: begin
                v = longint'(((u >> 25) << 5) | ((u >> 7) & 31));
                if (v >= 2048) v = v - 4096;
                d.imm = v[11:0];
            end
            7'h63: begin
                v = longint'((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                             (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1));
                if (v >= 4096) v = v - 8192;
            end
            7'h37, 7'h17: begin
                s = int'(u & 32'hFFFF_F000);
                v = longint'(s);
            end
            7'h6F: begin
                v = longint'((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                             (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1));
                if (v >= 1048576) v = v - 2097152;
            end
            default: v = 0;
        endcase
        d.imm64 = v;
        d.width_32 = (op == 7'h3B) || (op == 7'h1B);
        ill = !(op inside {7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73}) || ((u & 3) != 3);
        if ((op == 7'h33 || op == 7'h3B) && !(f7 inside {7'h00, 7'h20, 7'h01})) ill = 1'b1;
        if (op == 7'h3B && f7 == 7'h01 && f3 >= 3'd1 && f3 <= 3'd3) ill = 1'b1;
        if (op == 7'h1B && (f3 == 3'd1 || f3 == 3'd5) && ((u >> 25) & 1) == 1) ill = 1'b1;
        d.illegal = ill;
        d.pc = pc;
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  f7s[3];
        int          k;
        f7s = '{7'h00, 7'h20, 7'h01};
        r = $urandom;
        k = $urandom_range(0, 15);
        if (k < 13) r[6:0] = ops_tab[k];
        if ($urandom_range(0, 1) == 1) r[31:25] = f7s[$urandom_range(0, 2)];
        return r;
    endfunction

    // One clock of stimulus; the expected record is queued once the edge that accepts it has passed
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                         input logic ordy, input logic fl);
        logic exp_rdy;
        @(posedge clk);
        #1;
        if (pend) begin
            sb_q.push_back(pend_exp);
            pend = 1'b0;
        end
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = ((sb_q.size() == 0) || ordy) && !fl;
        chk64("in_ready", 64'(in_ready), 64'(exp_rdy));
        pend     = v && exp_rdy;
        pend_exp = ref_decode(ins, pc);
    endtask

    // Monitor: mid-cycle, compare the presented slot with the scoreboard head
    always @(negedge clk) begin
        if (!reset) begin
            chk64("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
            if (out_valid && sb_q.size() != 0) begin
                if (flush) begin
                    void'(sb_q.pop_front());
                end else begin
                    chk_inst("out_inst", out_inst, sb_q[0]);
                    if (out_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 64'd0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk64("rst_out_valid", 64'(out_valid), 64'd0);
        chk_inst("rst_out_inst", out_inst, '0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        chk64("ready_after_rst", 64'(in_ready), 64'd1);

        // Directed: ADDW, ADDI -1, LUI, all-zero word
        cycle(1'b1, 32'h00B5053B, 64'h1000, 1'b1, 1'b0);
        cycle(1'b1, 32'hFFF00093, 64'h1004, 1'b1, 1'b0);
        chk64("addw_valid", 64'(out_valid), 64'd1);
        chk64("addw_opcode", 64'(out_inst.opcode), 64'h3B);
        chk64("addw_rd", 64'(out_inst.rd), 64'd10);
        chk64("addw_rs1", 64'(out_inst.rs1), 64'd10);
        chk64("addw_rs2", 64'(out_inst.rs2), 64'd11);
        chk64("addw_funct7", 64'(out_inst.funct7), 64'd0);
        chk64("addw_w32", 64'(out_inst.width_32), 64'd1);
        chk64("addw_illegal", 64'(out_inst.illegal), 64'd0);
        cycle(1'b1, 32'h123452B7, 64'h1008, 1'b1, 1'b0);
        chk64("addi_imm", 64'(out_inst.imm), 64'hFFF);
        chk64("addi_imm64", out_inst.imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk64("addi_w32", 64'(out_inst.width_32), 64'd0);
        cycle(1'b1, 32'h00000000, 64'h100C, 1'b1, 1'b0);
        chk64("lui_imm64", out_inst.imm64, 64'h0000_0000_1234_5000);
        chk64("lui_imm", 64'(out_inst.imm), 64'd0);
        cycle(1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
        chk64("zero_illegal", 64'(out_inst.illegal), 64'd1);

        // Backpressure: three stalled cycles with a waiting input, then no-bubble reload
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h00208033, 64'h2000, 1'b0, 1'b0);
            chk64("bp_in_ready", 64'(in_ready), 64'd0);
        end
        cycle(1'b1, 32'h00208033, 64'h2000, 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        chk64("bp_reload_valid", 64'(out_valid), 64'd1);
        chk64("bp_reload_pc", out_inst.pc, 64'h2000);

        // Flush with a simultaneous input: both held and incoming are dropped
        cycle(1'b1, 32'h00A00513, 64'h3000, 1'b0, 1'b0);
        cycle(1'b1, 32'h00B00593, 64'h3004, 1'b0, 1'b1);
        cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        chk64("flush_valid", 64'(out_valid), 64'd0);

        // Reset while FULL clears the slot before the next edge
        cycle(1'b1, 32'h00C00613, 64'h4000, 1'b0, 1'b0);
        cycle(1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk64("midrst_valid", 64'(out_valid), 64'd0);
        chk_inst("midrst_inst", out_inst, '0);
        sb_q.delete();
        pend  = 1'b0;
        reset = 1'b0;
        #1;
        chk64("midrst_ready", 64'(in_ready), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) < 7, rand_instr(), {$urandom, $urandom},
                  $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        chk64("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
